// File: rtl/player_pkg.sv
// Shared types and constants for the overworld player controller.
//
// Contents:
//   state_t  - controller FSM states
//   dir_t    - facing encoding (0 down, 1 up, 2 left, 3 right)
//   ROW_*    - sprite-sheet row per facing
//   COL_*    - sprite-sheet column per pose
//   row_of() - facing to sheet row
//
// Optional feature macro: PLAYER_RUN_EN. When it is defined, the run rows sit
// 64 rows lower on the sheet. That offset does not fit in 6 bits, so the
// sprite row output is 7 bits wide in that build.
package player_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WALK      = 2'd1,
      ENC_CHECK = 2'd2,
      ENC_WAIT  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam logic [5:0] ROW_DOWN     = 6'd0;
   localparam logic [5:0] ROW_UP       = 6'd16;
   localparam logic [5:0] ROW_LEFT     = 6'd32;
   localparam logic [5:0] ROW_RIGHT    = 6'd48;

   localparam logic [5:0] COL_STAND    = 6'd0;
   localparam logic [5:0] COL_STRIDE_A = 6'd16;
   localparam logic [5:0] COL_STRIDE_B = 6'd32;

   localparam logic [7:0] LFSR_SEED    = 8'h5A;

`ifdef PLAYER_RUN_EN
   localparam int         SEL_Y_W      = 7;
   localparam logic [6:0] ROW_RUN_OFS  = 7'd64;
`else
   localparam int         SEL_Y_W      = 6;
`endif

   function automatic logic [5:0] row_of(input dir_t d);
      case (d)
         DIR_DOWN:  row_of = ROW_DOWN;
         DIR_UP:    row_of = ROW_UP;
         DIR_LEFT:  row_of = ROW_LEFT;
         DIR_RIGHT: row_of = ROW_RIGHT;
         default:   row_of = ROW_DOWN;
      endcase
   endfunction

endpackage

// File: rtl/player_motion_ctrl_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as the
// encounter dice. The seed is non-zero, so the output is never 0.
//
// Ports:
//   i_clk   - clock
//   i_reset - synchronous active-high reset, reloads the seed
//   i_en    - advance enable
//   o_q     - current register value
module player_motion_ctrl_lfsr
   import player_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_en,
   output logic [7:0] o_q
);

   logic [7:0] r_q;
   logic       w_fb;

   assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
   assign o_q  = r_q;

   // shift register with seed reload
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q <= LFSR_SEED;
      end else if (i_en) begin
         r_q <= {r_q[6:0], w_fb};
      end else begin
         r_q <= r_q;
      end
   end

endmodule

// File: rtl/player_motion_ctrl.sv
// Tile-grid overworld player controller. It latches a direction, animates a
// multi-frame step, commits the map scroll position and rolls for grass
// encounters. State advances on the frame tick (hcount==0 && vcount==0).
//
// Ports:
//   vclk, reset          - pixel clock, synchronous active-high reset
//   i_hcount, i_vcount   - raster position (frame tick source)
//   i_start              - overworld enable; low freezes all but the LFSR
//   i_up/down/left/right - held buttons (priority up > down > left > right)
//   i_fwd_blocked        - tile ahead of the facing direction is solid
//   i_cur_grass          - tile under the player is grass
//   i_battle_done        - releases ENC_WAIT
//   i_run                - (PLAYER_RUN_EN only) half-length step
//   o_map_x, o_map_y     - scroll position
//   o_facing, o_moving   - facing direction, high while walking
//   o_battle_trigger     - one-cycle encounter pulse
//   o_sprite_sel_x/_y    - sprite-sheet column / row
//   o_step_count         - saturating count of committed steps
//
// Optional feature macro: PLAYER_RUN_EN.
module player_motion_ctrl
   import player_pkg::*;
#(
   parameter int TILE        = 16,
   parameter int STEP_FRAMES = 16,
   parameter int START_X     = 432,
   parameter int START_Y     = 312,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 1024,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 768,
   parameter int ENC_THRESH  = 192
) (
   input  logic               vclk,
   input  logic               reset,
   input  logic [10:0]        i_hcount,
   input  logic [9:0]         i_vcount,
   input  logic               i_start,
   input  logic               i_up,
   input  logic               i_down,
   input  logic               i_left,
   input  logic               i_right,
   input  logic               i_fwd_blocked,
   input  logic               i_cur_grass,
   input  logic               i_battle_done,
`ifdef PLAYER_RUN_EN
   input  logic               i_run,
`endif
   output logic [10:0]        o_map_x,
   output logic [9:0]         o_map_y,
   output logic [1:0]         o_facing,
   output logic               o_moving,
   output logic               o_battle_trigger,
   output logic [5:0]         o_sprite_sel_x,
   output logic [SEL_Y_W-1:0] o_sprite_sel_y,
   output logic [15:0]        o_step_count
);

   localparam int FW = $clog2(STEP_FRAMES);
   // the commit happens on the tick that would enter the last frame
   localparam logic [FW-1:0] LAST_WALK   = FW'(STEP_FRAMES - 1);
   localparam logic [FW-1:0] LAST_RUN    = FW'(STEP_FRAMES / 2 - 1);
   localparam logic [FW-1:0] STRIDE_WALK = FW'(STEP_FRAMES / 2);
   localparam logic [FW-1:0] STRIDE_RUN  = FW'(STEP_FRAMES / 4);

   state_t              r_state, w_state_next;
   logic [FW-1:0]       r_frame, w_frame_next, w_frame_inc;
   logic                r_foot, w_foot_next;
   dir_t                r_facing, w_facing_next, w_dir;
   logic [10:0]         r_map_x, w_map_x_next;
   logic [9:0]          r_map_y, w_map_y_next;
   logic [5:0]          r_sel_x, w_sel_x_next, w_pose;
   logic [SEL_Y_W-1:0]  r_sel_y, w_sel_y_next, w_row_full;
   logic [15:0]         r_steps, w_steps_next;
   logic                r_trig, w_trig_next;
   logic                r_moving, w_moving_next;
   logic                r_run, w_run_next, w_run_in;
   logic                w_tick, w_any_dir, w_in_bounds, w_vert;
   logic [FW-1:0]       w_last, w_stride_start;
   logic [7:0]          w_lfsr_q;

   player_motion_ctrl_lfsr u_lfsr (
      .i_clk   (vclk),
      .i_reset (reset),
      .i_en    (1'b1),
      .o_q     (w_lfsr_q)
   );

`ifdef PLAYER_RUN_EN
   assign w_run_in   = i_run;
   assign w_row_full = {1'b0, row_of(w_dir)} + (w_run_in ? ROW_RUN_OFS : 7'd0);
`else
   assign w_run_in   = 1'b0;
   assign w_row_full = row_of(w_dir);
`endif

   assign w_tick         = (i_hcount == 11'd0) && (i_vcount == 10'd0);
   assign w_any_dir      = i_up | i_down | i_left | i_right;
   assign w_vert         = (r_facing == DIR_UP) || (r_facing == DIR_DOWN);
   assign w_frame_inc    = r_frame + FW'(1);
   assign w_last         = r_run ? LAST_RUN : LAST_WALK;
   assign w_stride_start = r_run ? STRIDE_RUN : STRIDE_WALK;

   // button priority encoder
   always_comb begin
      w_dir = DIR_DOWN;
      if (i_up) begin
         w_dir = DIR_UP;
      end else if (i_down) begin
         w_dir = DIR_DOWN;
      end else if (i_left) begin
         w_dir = DIR_LEFT;
      end else if (i_right) begin
         w_dir = DIR_RIGHT;
      end else begin
         w_dir = DIR_DOWN;
      end
   end

   // would one tile of movement in w_dir stay inside the map bounds
   always_comb begin
      w_in_bounds = 1'b0;
      case (w_dir)
         DIR_UP:    w_in_bounds = (int'(r_map_y) + TILE) <= Y_MAX;
         DIR_DOWN:  w_in_bounds = (int'(r_map_y) - TILE) >= Y_MIN;
         DIR_LEFT:  w_in_bounds = (int'(r_map_x) + TILE) <= X_MAX;
         DIR_RIGHT: w_in_bounds = (int'(r_map_x) - TILE) >= X_MIN;
         default:   w_in_bounds = 1'b0;
      endcase
   end

   // sprite column for the frame being entered
   always_comb begin
      w_pose = COL_STAND;
      if (w_frame_inc < w_stride_start) begin
         w_pose = COL_STAND;
      end else if (w_vert) begin
         w_pose = r_foot ? COL_STRIDE_B : COL_STRIDE_A;
      end else begin
         w_pose = COL_STRIDE_A;
      end
   end

   // next-state and next-output logic
   always_comb begin
      w_state_next  = r_state;
      w_frame_next  = r_frame;
      w_foot_next   = r_foot;
      w_facing_next = r_facing;
      w_map_x_next  = r_map_x;
      w_map_y_next  = r_map_y;
      w_sel_x_next  = r_sel_x;
      w_sel_y_next  = r_sel_y;
      w_steps_next  = r_steps;
      w_trig_next   = 1'b0;
      w_run_next    = r_run;
      if (i_start) begin
         case (r_state)
            IDLE: begin
               if (w_tick && w_any_dir) begin
                  w_facing_next = w_dir;
                  w_sel_y_next  = w_row_full;
                  if (!i_fwd_blocked && w_in_bounds) begin
                     w_state_next = WALK;
                     w_frame_next = '0;
                     w_sel_x_next = COL_STAND;
                     w_run_next   = w_run_in;
                  end else begin
                     w_state_next = IDLE;
                  end
               end else begin
                  w_state_next = IDLE;
               end
            end
            WALK: begin
               if (w_tick && (w_frame_inc == w_last)) begin
                  w_state_next = ENC_CHECK;
                  w_frame_next = '0;
                  w_sel_x_next = COL_STAND;
                  w_foot_next  = w_vert ? ~r_foot : r_foot;
                  w_steps_next = (r_steps == 16'hFFFF) ? r_steps : r_steps + 16'd1;
                  case (r_facing)
                     DIR_UP:    w_map_y_next = r_map_y + 10'(TILE);
                     DIR_DOWN:  w_map_y_next = r_map_y - 10'(TILE);
                     DIR_LEFT:  w_map_x_next = r_map_x + 11'(TILE);
                     DIR_RIGHT: w_map_x_next = r_map_x - 11'(TILE);
                     default:   w_map_x_next = r_map_x;
                  endcase
               end else if (w_tick) begin
                  w_frame_next = w_frame_inc;
                  w_sel_x_next = w_pose;
               end else begin
                  w_state_next = WALK;
               end
            end
            ENC_CHECK: begin
               // cur_grass reflects the freshly committed position here
               if (i_cur_grass && (w_lfsr_q > 8'(ENC_THRESH))) begin
                  w_trig_next  = 1'b1;
                  w_state_next = ENC_WAIT;
               end else begin
                  w_state_next = IDLE;
               end
            end
            ENC_WAIT: begin
               if (i_battle_done) begin
                  w_state_next = IDLE;
               end else begin
                  w_state_next = ENC_WAIT;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end else begin
         w_state_next = r_state;
      end
      w_moving_next = (w_state_next == WALK);
   end

   // state and output registers
   always_ff @(posedge vclk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_frame  <= '0;
         r_foot   <= 1'b0;
         r_facing <= DIR_DOWN;
         r_map_x  <= 11'(START_X);
         r_map_y  <= 10'(START_Y);
         r_sel_x  <= COL_STAND;
         r_sel_y  <= '0;
         r_steps  <= 16'd0;
         r_trig   <= 1'b0;
         r_moving <= 1'b0;
         r_run    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_frame  <= w_frame_next;
         r_foot   <= w_foot_next;
         r_facing <= w_facing_next;
         r_map_x  <= w_map_x_next;
         r_map_y  <= w_map_y_next;
         r_sel_x  <= w_sel_x_next;
         r_sel_y  <= w_sel_y_next;
         r_steps  <= w_steps_next;
         r_trig   <= w_trig_next;
         r_moving <= w_moving_next;
         r_run    <= w_run_next;
      end
   end

   assign o_map_x          = r_map_x;
   assign o_map_y          = r_map_y;
   assign o_facing         = r_facing;
   assign o_moving         = r_moving;
   assign o_battle_trigger = r_trig;
   assign o_sprite_sel_x   = r_sel_x;
   assign o_sprite_sel_y   = r_sel_y;
   assign o_step_count     = r_steps;

endmodule
